// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer: funct3 codes,
// state encoding and ALU control values.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ABS_A  = 3'd1;
    localparam logic [2:0] ST_ABS_B  = 3'd2;
    localparam logic [2:0] ST_ITER   = 3'd3;
    localparam logic [2:0] ST_FIX_LO = 3'd4;
    localparam logic [2:0] ST_FIX_HI = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_ABS_A  = ST_ABS_A,
        S_ABS_B  = ST_ABS_B,
        S_ITER   = ST_ITER,
        S_FIX_LO = ST_FIX_LO,
        S_FIX_HI = ST_FIX_HI,
        S_DONE   = ST_DONE
    } state_e;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam int         ITER_COUNT = 32;

endpackage

// File: rtl/muldiv_sequencer.sv
// Fixed 37-cycle RV32M multiply/divide/remainder controller that drives the
// core's shared add/subtract ALU; sign handling is done by magnitude + fix-up.
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_switch,
    output logic [2:0]  alu_operation,
    input  logic [31:0] alu_o,
    input  logic        alu_c,
    output logic [2:0]  dbg_state
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d;        // product high word / remainder R
    logic [31:0] lo_q, lo_d;        // product low word / quotient Q
    logic [31:0] b_q, b_d;          // rs2, then |b|
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic        lo_nz_q, lo_nz_d;
    logic [31:0] fix_lo_q, fix_lo_d;
    logic [31:0] result_q, result_d;

    logic [31:0] cand;
    logic        take;
    logic        is_div;
    logic        is_rem;
    logic        neg;
    logic        negq;
    logic        signed_a;
    logic        signed_b;

    assign cand     = {hi_q[30:0], lo_q[31]};
    assign take     = ~alu_c | hi_q[31];
    assign is_div   = op_q[2];
    assign is_rem   = op_q[2] & op_q[1];
    assign neg      = sa_q ^ sb_q;
    assign negq     = (sa_q ^ sb_q) & (b_q != 32'd0);
    assign signed_a = (funct3 == F3_MULH) | (funct3 == F3_MULHSU) |
                      (funct3 == F3_DIV)  | (funct3 == F3_REM);
    assign signed_b = (funct3 == F3_MULH) | (funct3 == F3_DIV) | (funct3 == F3_REM);

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign result        = result_q;
    assign alu_operation = ALU_ADD;
    assign dbg_state     = state_q;

    // ALU operands depend on registered state only, so no path runs from
    // alu_o/alu_c back into alu_a/alu_b.
    always_comb begin
        alu_a      = 32'd0;
        alu_b      = 32'd0;
        alu_switch = 1'b0;
        case (state_q)
            S_ABS_A: begin
                alu_b      = lo_q;
                alu_switch = 1'b1;
            end
            S_ABS_B: begin
                alu_b      = b_q;
                alu_switch = 1'b1;
            end
            S_ITER: begin
                if (is_div) begin
                    alu_a      = cand;
                    alu_b      = b_q;
                    alu_switch = 1'b1;
                end else begin
                    alu_a = hi_q;
                    alu_b = lo_q[0] ? b_q : 32'd0;
                end
            end
            S_FIX_LO: begin
                alu_b      = is_rem ? hi_q : lo_q;
                alu_switch = 1'b1;
            end
            S_FIX_HI: begin
                alu_a = ~hi_q;
                alu_b = {31'd0, ~lo_nz_q};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        lo_nz_d  = lo_nz_q;
        fix_lo_d = fix_lo_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ABS_A;
                    op_d    = funct3;
                    lo_d    = rs1;
                    b_d     = rs2;
                    hi_d    = 32'd0;
                    cnt_d   = 5'd0;
                    sa_d    = signed_a & rs1[31];
                    sb_d    = signed_b & rs2[31];
                end
            end
            S_ABS_A: begin
                if (sa_q) lo_d = alu_o;
                state_d = S_ABS_B;
            end
            S_ABS_B: begin
                if (sb_q) b_d = alu_o;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (is_div) begin
                    hi_d = take ? alu_o : cand;
                    lo_d = {lo_q[30:0], take};
                end else begin
                    hi_d = {alu_c, alu_o[31:1]};
                    lo_d = {alu_o[0], lo_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(ITER_COUNT - 1)) state_d = S_FIX_LO;
            end
            S_FIX_LO: begin
                fix_lo_d = alu_o;
                lo_nz_d  = alu_c;
                state_d  = S_FIX_HI;
            end
            S_FIX_HI: begin
                // Written on the edge into DONE so the value is valid with done.
                case (op_q)
                    F3_MUL:                        result_d = neg  ? fix_lo_q : lo_q;
                    F3_MULH, F3_MULHSU, F3_MULHU:  result_d = neg  ? alu_o    : hi_q;
                    F3_DIV, F3_DIVU:               result_d = negq ? fix_lo_q : lo_q;
                    default:                       result_d = sa_q ? fix_lo_q : hi_q;
                endcase
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            b_q      <= 32'd0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            lo_nz_q  <= 1'b0;
            fix_lo_q <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            lo_nz_q  <= lo_nz_d;
            fix_lo_q <= fix_lo_d;
            result_q <= result_d;
        end
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller that runs the RV32M multiply, divide and remainder instructions on the core's shared 32-bit ALU. It uses only the ALU's add/subtract path and its carry output. While an operation runs, the core-level mux hands the ALU to this block. Every operation has a fixed 37-cycle latency, so hazard logic can count cycles without inspecting operands.

## Interface
Parameters: none (32-bit datapath fixed).

- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1, rs2  in  32  operands, sampled on the accept edge
- busy  out  1  high from the cycle after accept through the DONE cycle
- done  out  1  one-cycle pulse; result is valid in that cycle
- result  out  32  result register, held until the next done
- alu_a, alu_b  out  32  shared ALU operands
- alu_switch  out  1  0 = add, 1 = subtract
- alu_operation  out  3  constant 3'b000 (the add path, so the carry is valid)
- alu_o  in  32  ALU result
- alu_c  in  1  ALU carry; after a subtract this is the borrow (1 when A < B unsigned)

## Operation
- States: IDLE → ABS_A → ABS_B → ITER (×32) → FIX_LO → FIX_HI → DONE → IDLE.
- Every state is always visited, whatever the operand signs or values.
- Signed-operand flags:
  - sa = rs1[31] for MULH, MULHSU, DIV, REM.
  - sb = rs2[31] for MULH, DIV, REM.
- ABS_A: ALU computes 0 − rs1. Latch the magnitude |a| = sa ? alu_o : rs1.
- ABS_B: same for rs2, giving |b|.
- ITER for multiply, with hi=0 and lo=|a| at entry:
  - ALU computes hi + (lo[0] ? |b| : 0).
  - Then hi ← {alu_c, alu_o[31:1]} and lo ← {alu_o[0], lo[31:1]}.
- ITER for divide, with R=0 and Q=|a| at entry:
  - cand = {R[30:0], Q[31]}; ALU computes cand − |b|.
  - take = ~alu_c | R[31]. R[31]=1 means cand ≥ 2^32 > |b|, so the subtract must be taken.
  - R ← take ? alu_o : cand; Q ← {Q[30:0], take}.
- Negate flags:
  - multiply: neg = sa ^ sb.
  - quotient: negq = (sa ^ sb) & (rs2 ≠ 0).
  - remainder: negr = sa.
- FIX_LO: ALU computes 0 − low word (lo, Q or R). The borrow is kept as lo_nz.
- FIX_HI (MULH/MULHSU/MULHU only): ALU computes ~hi + !lo_nz, i.e. the high half of the 64-bit negation.
- DONE: result register is loaded:
  - MUL: the low word, negated if neg.
  - MULH*: the high word, negated if neg.
  - DIV*: Q, negated if negq.
  - REM*: R, negated if negr.
- Boundary cases fall out of the algorithm with no special path:
  - Divide by zero gives Q = 0xFFFFFFFF and R = rs1.
  - 0x80000000 / −1 gives Q = 0x80000000 and R = 0.
- start while busy is ignored. start in DONE is also ignored; it is accepted from IDLE only.
- alu_* outputs are don't-care in IDLE and DONE. alu_operation is always 000.

## Timing
- The accept edge is the rising edge with IDLE & start. ABS_A is cycle 1, ITER is cycles 3–34, FIX_LO is cycle 35, FIX_HI is cycle 36, DONE is cycle 37.
- done=1 and the valid result appear in cycle 37. busy is high in cycles 1–37, and the next start is accepted in cycle 38 at the earliest.
- The ALU is combinational; each state's ALU result is registered on that state's closing edge.
- Reset values: state=IDLE, busy=0, done=0, result=0, all internal registers 0.
- rst at any cycle, including mid-ITER, gives the reset values on the next edge. rst outranks start.

## Structure
- Shared package `muldiv_pkg`:
  - funct3 constants.
  - state encoding localparams.
  - ALU_ADD = 3'b000.
  - ITER_COUNT = 32.
- One module. No sub-module is needed; the iteration counter is a 5-bit register inside it.
- The ALU itself stays outside and is shared through the core mux.

## Test plan
- MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB, with done exactly 37 cycles after accept.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM of the same → 0xFFFFFFFF. DIVU 0xFFFFFFFF / 0x80000001 → 1 (exercises the R[31] force path).
- DIVU 5 / 0 → 0xFFFFFFFF. REM 0xFFFFFFFB / 0 → 0xFFFFFFFB. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same → 0.
- start pulsed during busy, including in the DONE cycle → ignored. A second start in cycle 38 → accepted, with the correct result at cycle 75.
- rst asserted in cycle 10 → busy=0, done=0, result=0 next cycle. No done pulse follows. A fresh start then works normally.
